// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, start, data, parity, stop, ack and timeout
// Ports:
//   clk, rst_n               system clock, asynchronous active-low reset
//   ps2_clk_in, ps2_data_in  raw PS/2 line samples (synchronized internally)
//   ps2_clk_oe, ps2_data_oe  open-drain pull-low enables for the PS/2 lines
//   tx_data, tx_valid        command byte and send request
//   tx_ready, busy           idle / in-transfer status
//   done, ack_err, timeout_err  end-of-transfer pulse with its error flags
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);
    localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE, FINISH} state_t;
    state_t state, state_n;
    logic [2:0] ck_s;
    logic [1:0] dt_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] bits, bits_n;
    logic [8:0] sh, sh_n;
    logic dreg, dreg_n, ack_r, ack_n, to_r, to_n;
    logic fall, ck_sync, dt_sync, expired;
    // ck_s[1] is the synchronized clock, ck_s[2] its previous value
    assign ck_sync = ck_s[1];
    assign dt_sync = dt_s[1];
    assign fall = ck_s[2] & ~ck_s[1];
    assign expired = 32'(cnt) + 1 >= TIMEOUT_CYCLES;
    // the REQ cycle also holds the clock low, so INHIBIT lasts one cycle less
    // and the total clock-low time equals INHIBIT_CYCLES
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        bits_n = bits;
        sh_n = sh;
        dreg_n = dreg;
        ack_n = ack_r;
        to_n = to_r;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    state_n = INHIBIT;
                    sh_n = {~^tx_data, tx_data};
                    bits_n = '0;
                    ack_n = 1'b0;
                    to_n = 1'b0;
                end
            end
            INHIBIT: state_n = (32'(cnt) + 2 >= INHIBIT_CYCLES) ? REQ : INHIBIT;
            REQ: begin
                state_n = SEND;
                cnt_n = '0;
                dreg_n = 1'b1;
            end
            SEND: begin
                if (expired) begin
                    state_n = FINISH;
                    to_n = 1'b1;
                    dreg_n = 1'b0;
                end else if (fall) begin
                    bits_n = bits + 1'b1;
                    if (bits < 4'd9) begin
                        dreg_n = ~sh[0];
                        sh_n = sh >> 1;
                    end else if (bits == 4'd9) begin
                        dreg_n = 1'b0;
                    end else begin
                        ack_n = dt_sync;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (expired) begin
                    state_n = FINISH;
                    to_n = 1'b1;
                end else if (ck_sync & dt_sync) begin
                    state_n = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ck_s <= '1;
            dt_s <= '1;
            cnt <= '0;
            bits <= '0;
            sh <= '0;
            dreg <= 1'b0;
            ack_r <= 1'b0;
            to_r <= 1'b0;
        end else begin
            state <= state_n;
            ck_s <= {ck_s[1:0], ps2_clk_in};
            dt_s <= {dt_s[0], ps2_data_in};
            cnt <= cnt_n;
            bits <= bits_n;
            sh <= sh_n;
            dreg <= dreg_n;
            ack_r <= ack_n;
            to_r <= to_n;
        end
    end
    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = (state == REQ) || ((state == SEND) && dreg);
    assign tx_ready = state == IDLE;
    assign busy = ~tx_ready;
    assign done = state == FINISH;
    assign ack_err = done & ack_r & ~to_r;
    assign timeout_err = done & to_r;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench with a behavioural PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 10;
    localparam int TO = 2000;
    localparam int HP = 50;
    logic clk = 0, rst_n = 0;
    logic dev_clk = 1, dev_data = 1;
    logic ps2_clk_in, ps2_data_in, clk_oe, data_oe;
    logic [7:0] tx_data = 0;
    logic tx_valid = 0;
    logic tx_ready, busy, done, ack_err, timeout_err;
    int checks = 0, errors = 0, oe_cnt = 0, done_cnt = 0;
    assign ps2_clk_in = dev_clk & ~clk_oe;
    assign ps2_data_in = dev_data & ~data_oe;
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (clk_oe) oe_cnt++;
        if (done) done_cnt++;
    end
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k <= 8) return ~b[k-1];
        if (k == 9) return ($countones(b) % 2) == 1;
        return 1'b0;
    endfunction
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic accept(input logic [7:0] b);
        tx_data = b;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
    endtask
    task automatic wait_release(output bit ok);
        int n = 0;
        while (!clk_oe && n < 100) begin @(negedge clk); n++; end
        while (clk_oe && n < 100) begin @(negedge clk); n++; end
        ok = n < 100;
    endtask
    task automatic device(input bit ack, output logic [10:1] seen, output bit ok);
        wait_release(ok);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) dev_data = 0;
            dev_clk = 1;
            cyc(HP);
            dev_clk = 0;
            cyc(HP);
            if (k <= 10) seen[k] = data_oe;
        end
        dev_clk = 1;
        dev_data = 1;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
    endtask
    task automatic test_reset;
        #1;
        checks++; if (clk_oe !== 0) begin errors++; $display("FAIL rst_clk_oe got %b want 0", clk_oe); end
        checks++; if (data_oe !== 0) begin errors++; $display("FAIL rst_data_oe got %b want 0", data_oe); end
        checks++; if (done !== 0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if ({ack_err, timeout_err} !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", {ack_err, timeout_err}); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        cyc(3);
        rst_n = 1;
        cyc(2);
        checks++; if (tx_ready !== 1) begin errors++; $display("FAIL rst_ready got %b want 1", tx_ready); end
    endtask
    task automatic test_frame(input logic [7:0] b, input bit ack);
        logic [10:1] seen;
        bit ok;
        int n, d0;
        d0 = done_cnt;
        oe_cnt = 0;
        checks++; if (tx_ready !== 1) begin errors++; $display("FAIL frame_ready got %b want 1", tx_ready); end
        accept(b);
        device(ack, seen, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_release got timeout want release"); end
        checks++; if (oe_cnt !== INH) begin errors++; $display("FAIL inhibit_len got %0d want %0d", oe_cnt, INH); end
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (seen[k] !== exp_bit(b, k)) begin errors++; $display("FAIL byte %h fall%0d data_oe got %b want %b", b, k, seen[k], exp_bit(b, k)); end
        end
        wait_done(n);
        checks++; if (done !== 1) begin errors++; $display("FAIL frame_done got %b want 1", done); end
        checks++; if (ack_err !== !ack) begin errors++; $display("FAIL ack_err got %b want %b", ack_err, !ack); end
        checks++; if (timeout_err !== 0) begin errors++; $display("FAIL frame_timeout got %b want 0", timeout_err); end
        cyc(1);
        checks++; if (done !== 0 || done_cnt != d0 + 1) begin errors++; $display("FAIL done_pulse got %0d want %0d", done_cnt - d0, 1); end
        checks++; if ({ack_err, timeout_err} !== 2'b00) begin errors++; $display("FAIL err_after got %b want 00", {ack_err, timeout_err}); end
    endtask
    task automatic test_timeout;
        bit ok;
        int n;
        accept(8'($urandom));
        wait_release(ok);
        wait_done(n);
        checks++; if (n !== TO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", n, TO); end
        checks++; if (timeout_err !== 1 || ack_err !== 0) begin errors++; $display("FAIL timeout_flags got %b want 10", {timeout_err, ack_err}); end
        checks++; if ({clk_oe, data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe got %b want 00", {clk_oe, data_oe}); end
        cyc(2);
    endtask
    task automatic test_reset_mid;
        bit ok;
        int d0;
        d0 = done_cnt;
        accept(8'($urandom) & 8'hF7);
        wait_release(ok);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1;
            cyc(HP);
            dev_clk = 0;
            cyc(k == 4 ? HP / 2 : HP);
        end
        checks++; if (data_oe !== 1) begin errors++; $display("FAIL mid_bit4 data_oe got %b want 1", data_oe); end
        #1 rst_n = 0;
        #1;
        checks++; if ({clk_oe, data_oe} !== 2'b00) begin errors++; $display("FAIL mid_rst_oe got %b want 00", {clk_oe, data_oe}); end
        checks++; if (done !== 0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
        dev_clk = 1;
        cyc(3);
        rst_n = 1;
        cyc(1500);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_no_done got %0d want %0d", done_cnt, d0); end
        checks++; if (tx_ready !== 1) begin errors++; $display("FAIL mid_ready got %b want 1", tx_ready); end
    endtask
    task automatic test_back_to_back;
        logic [10:1] s1, s2;
        bit ok1, ok2;
        int n, low;
        tx_data = 8'hF4;
        tx_valid = 1;
        @(negedge clk);
        tx_data = 8'hED;
        device(1, s1, ok1);
        wait_done(n);
        checks++; if (done !== 1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done); end
        low = 0;
        cyc(1);
        while (!busy && low < 10) begin low++; @(negedge clk); end
        tx_valid = 0;
        checks++; if (low !== 1) begin errors++; $display("FAIL b2b_busy_low got %0d want 1", low); end
        device(1, s2, ok2);
        wait_done(n);
        checks++; if (!ok1 || !ok2 || done !== 1) begin errors++; $display("FAIL b2b_frames got %b%b%b want 111", ok1, ok2, done); end
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (s1[k] !== exp_bit(8'hF4, k) || s2[k] !== exp_bit(8'hED, k))
                begin errors++; $display("FAIL b2b fall%0d got %b%b want %b%b", k, s1[k], s2[k], exp_bit(8'hF4, k), exp_bit(8'hED, k)); end
        end
        cyc(2);
    endtask
    initial begin
        test_reset;
        test_frame(8'hED, 1);
        test_frame(8'h00, 0);
        for (int i = 0; i < 4; i++) test_frame(8'($urandom), 1'($urandom));
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
